// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bundle for the pipelined ALU.
package alu_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [OPCODE_W-1:0] {
        OP_ADD    = 4'h0,
        OP_SUBWB  = 4'h1,
        OP_MOV    = 4'h2,
        OP_SUB    = 4'h3,
        OP_INC    = 4'h4,
        OP_DEC    = 4'h5,
        OP_ADDINC = 4'h6,
        OP_AND    = 4'h8,
        OP_OR     = 4'h9,
        OP_XOR    = 4'hA,
        OP_NOT    = 4'hB,
        OP_SHL    = 4'hD
    } alu_op_t;

    typedef struct packed {
        logic c;
        logic z;
        logic o;
        logic s;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: one result plus carry/zero/overflow/sign/error flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DWIDTH-1:0]   op1,
    input  logic [DWIDTH-1:0]   op2,
    input  logic                c_in,
    output logic [DWIDTH-1:0]   result,
    output logic                c_flag,
    output logic                z_flag,
    output logic                o_flag,
    output logic                s_flag,
    output logic                err
);

    localparam int SHW = $clog2(DWIDTH);

    logic [DWIDTH:0]   wide;
    logic [DWIDTH-1:0] b_val;
    logic [SHW-1:0]    shamt;
    logic              arith;
    logic              is_sub;
    logic              defined;
    logic              a_msb;
    logic              b_msb;
    logic              r_msb;

    assign shamt = op2[SHW-1:0];

    // Bit DWIDTH of the extended result is the carry/borrow for arithmetic,
    // the last bit shifted out for shl, and stays 0 for logic ops and mov.
    always_comb begin
        wide    = '0;
        b_val   = op2;
        arith   = 1'b0;
        is_sub  = 1'b0;
        defined = 1'b1;
        case (opcode)
            OP_ADD: begin
                wide  = {1'b0, op1} + {1'b0, op2};
                arith = 1'b1;
            end
            OP_ADDINC: begin
                wide  = {1'b0, op1} + {1'b0, op2} + {{DWIDTH{1'b0}}, c_in};
                arith = 1'b1;
            end
            OP_INC: begin
                b_val = {{(DWIDTH-1){1'b0}}, 1'b1};
                wide  = {1'b0, op1} + {{DWIDTH{1'b0}}, 1'b1};
                arith = 1'b1;
            end
            OP_SUB: begin
                wide   = {1'b0, op1} - {1'b0, op2};
                arith  = 1'b1;
                is_sub = 1'b1;
            end
            OP_SUBWB: begin
                wide   = {1'b0, op1} - {1'b0, op2} - {{DWIDTH{1'b0}}, c_in};
                arith  = 1'b1;
                is_sub = 1'b1;
            end
            OP_DEC: begin
                b_val  = {{(DWIDTH-1){1'b0}}, 1'b1};
                wide   = {1'b0, op1} - {{DWIDTH{1'b0}}, 1'b1};
                arith  = 1'b1;
                is_sub = 1'b1;
            end
            OP_MOV: wide = {1'b0, op2};
            OP_AND: wide = {1'b0, op1 & op2};
            OP_OR:  wide = {1'b0, op1 | op2};
            OP_XOR: wide = {1'b0, op1 ^ op2};
            OP_NOT: wide = {1'b0, ~op1};
            OP_SHL: wide = {1'b0, op1} << shamt;
            default: defined = 1'b0;
        endcase
    end

    assign a_msb  = op1[DWIDTH-1];
    assign b_msb  = b_val[DWIDTH-1];
    assign r_msb  = wide[DWIDTH-1];

    assign result = wide[DWIDTH-1:0];
    assign c_flag = defined & wide[DWIDTH];
    assign z_flag = defined & (wide[DWIDTH-1:0] == '0);
    assign s_flag = defined & r_msb;
    assign o_flag = arith & (r_msb != a_msb) & (is_sub ? (a_msb != b_msb) : (a_msb == b_msb));
    assign err    = ~defined;

endmodule

// File: rtl/alu_pipe.sv
// ALU front end with a carry-chaining state bit and a DEPTH-entry result FIFO.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [DWIDTH-1:0]   op1,
    input  logic [DWIDTH-1:0]   op2,
    input  logic                carry_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DWIDTH-1:0]   result,
    output logic                c_flag,
    output logic                z_flag,
    output logic                o_flag,
    output logic                s_flag,
    output logic                err
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;
    logic [PW:0]       count_reg;
    logic              c_state_reg;

    logic              push;
    logic              pop;
    logic              full;
    logic              c_in;

    logic [DWIDTH-1:0] core_result;
    logic              core_c;
    logic              core_z;
    logic              core_o;
    logic              core_s;
    logic              core_err;
    alu_flags_t        core_flags;
    alu_flags_t        head_flags;

    logic [DWIDTH-1:0] res_mem  [DEPTH];
    alu_flags_t        flag_mem [DEPTH];

    assign full      = (count_reg == (PW+1)'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign in_ready  = !full || (out_ready && out_valid);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // A coincident clear takes effect for the op being accepted this cycle.
    assign c_in = carry_clr ? 1'b0 : c_state_reg;

    alu_core #(
        .DWIDTH(DWIDTH)
    ) u_core (
        .opcode(opcode),
        .op1   (op1),
        .op2   (op2),
        .c_in  (c_in),
        .result(core_result),
        .c_flag(core_c),
        .z_flag(core_z),
        .o_flag(core_o),
        .s_flag(core_s),
        .err   (core_err)
    );

    assign core_flags = '{c: core_c, z: core_z, o: core_o, s: core_s, err: core_err};

    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr_reg]  <= core_result;
            flag_mem[wr_ptr_reg] <= core_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            c_state_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (push && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (pop && !push) begin
                count_reg <= count_reg - 1'b1;
            end
            // Undefined ops leave the carry alone unless a clear is requested.
            if (push && !core_err) begin
                c_state_reg <= core_c;
            end else if (carry_clr) begin
                c_state_reg <= 1'b0;
            end
        end
    end

    // Storage is never reset, so the head is masked to zero while empty.
    assign head_flags = out_valid ? flag_mem[rd_ptr_reg] : '0;
    assign result     = out_valid ? res_mem[rd_ptr_reg] : '0;
    assign c_flag     = head_flags.c;
    assign z_flag     = head_flags.z;
    assign o_flag     = head_flags.o;
    assign s_flag     = head_flags.s;
    assign err        = head_flags.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed literal cases plus randomized traffic vs a queue model.
module tb_alu_pipe;

    localparam int DWIDTH = 32;
    localparam int DEPTH  = 2;
    localparam longint UMAX = 64'sd4294967295;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        z;
        logic        o;
        logic        s;
        logic        e;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  opcode = 4'h0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        carry_clr = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        c_flag, z_flag, o_flag, s_flag, err;

    int total = 0;
    int bad = 0;

    ent_t q[$];
    logic mc = 1'b0;
    ent_t exp_h;
    logic exp_rdy;

    alu_pipe #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .op1      (op1),
        .op2      (op2),
        .carry_clr(carry_clr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .c_flag   (c_flag),
        .z_flag   (z_flag),
        .o_flag   (o_flag),
        .s_flag   (s_flag),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t ref_op(input logic [3:0] op, input logic [31:0] a,
                                    input logic [31:0] b, input logic cin);
        ent_t   e;
        longint ua, ub, sa, sb, ur, sr;
        int     amt;
        bit     arith;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ur = 0;
        sr = 0;
        arith = 1'b1;
        e = '0;
        case (op)
            4'h0: begin ur = ua + ub;        sr = sa + sb;        e.c = (ur > UMAX); end
            4'h6: begin ur = ua + ub + cin;  sr = sa + sb + cin;  e.c = (ur > UMAX); end
            4'h4: begin ur = ua + 1;         sr = sa + 1;         e.c = (ur > UMAX); end
            4'h3: begin ur = ua - ub;        sr = sa - sb;        e.c = (ur < 0); end
            4'h1: begin ur = ua - ub - cin;  sr = sa - sb - cin;  e.c = (ur < 0); end
            4'h5: begin ur = ua - 1;         sr = sa - 1;         e.c = (ur < 0); end
            4'h2: begin ur = ub;             arith = 1'b0; end
            4'h8: begin ur = longint'(a & b); arith = 1'b0; end
            4'h9: begin ur = longint'(a | b); arith = 1'b0; end
            4'hA: begin ur = longint'(a ^ b); arith = 1'b0; end
            4'hB: begin ur = longint'(~a);    arith = 1'b0; end
            4'hD: begin
                amt = int'(b[4:0]);
                ur = longint'(a << amt);
                arith = 1'b0;
                e.c = (amt == 0) ? 1'b0 : a[32 - amt];
            end
            default: begin
                e.e = 1'b1;
                return e;
            end
        endcase
        e.r = ur[31:0];
        e.o = arith && (sr > SMAX || sr < SMIN);
        e.z = (e.r == 32'h0);
        e.s = e.r[31];
        return e;
    endfunction

    // Reference model: FIFO of expected head entries plus the carry bit.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                q.delete();
                mc = 1'b0;
            end else begin
                bit   m_push, m_pop, m_rdy;
                ent_t e;
                m_rdy  = (q.size() < DEPTH) || (out_ready && q.size() > 0);
                m_push = in_valid && m_rdy;
                m_pop  = out_ready && (q.size() > 0);
                e = ref_op(opcode, op1, op2, carry_clr ? 1'b0 : mc);
                if (m_pop) void'(q.pop_front());
                if (m_push) begin
                    q.push_back(e);
                    if (!e.e) mc = e.c;
                    else if (carry_clr) mc = 1'b0;
                end else if (carry_clr) begin
                    mc = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            exp_rdy = (q.size() < DEPTH) || (out_ready && q.size() > 0);
            exp_h = (q.size() > 0) ? q[0] : '0;
            chk("model_in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("model_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("model_head", 64'({result, c_flag, z_flag, o_flag, s_flag, err}), 64'(exp_h));
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic clr);
        in_valid  = 1'b1;
        opcode    = op;
        op1       = a;
        op2       = b;
        carry_clr = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        carry_clr = 1'b0;
    endtask

    task automatic head(input string name, input logic [31:0] r, input logic [4:0] f);
        chk(name, 64'({out_valid, result, c_flag, z_flag, o_flag, s_flag, err}), 64'({1'b1, r, f}));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_result", 64'(result), 64'd0);
        out_ready = 1'b1;

        // Flag bit order in head(): {c, z, o, s, err}
        send(4'h0, 32'hFFFF_FFFF, 32'h1, 1'b0); head("add_wrap", 32'h0, 5'b11000);
        send(4'h0, 32'h7FFF_FFFF, 32'h1, 1'b0); head("add_ovf", 32'h8000_0000, 5'b00110);
        send(4'h6, 32'h0, 32'h0, 1'b0);         head("addinc_c0", 32'h0, 5'b01000);
        send(4'h0, 32'hFFFF_FFFF, 32'h1, 1'b0); head("add_wrap2", 32'h0, 5'b11000);
        send(4'h6, 32'h5, 32'h5, 1'b0);         head("addinc_chain", 32'hB, 5'b00000);
        send(4'h3, 32'h3, 32'h5, 1'b0);         head("sub_borrow", 32'hFFFF_FFFE, 5'b10010);
        send(4'h1, 32'hA, 32'h2, 1'b0);         head("subwb_chain", 32'h7, 5'b00000);
        send(4'h3, 32'h3, 32'h5, 1'b0);         head("sub_borrow2", 32'hFFFF_FFFE, 5'b10010);
        send(4'h1, 32'hA, 32'h2, 1'b1);         head("subwb_clr", 32'h8, 5'b00000);
        send(4'hD, 32'h8000_0001, 32'h1, 1'b0); head("shl_out", 32'h2, 5'b10000);
        send(4'h7, 32'h5, 32'h5, 1'b0);         head("undef_op", 32'h0, 5'b00001);
        send(4'h6, 32'h0, 32'h0, 1'b0);         head("undef_keeps_c", 32'h1, 5'b00000);

        // Reset with two entries queued and the carry set.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(4'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        send(4'h0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        chk("two_queued_valid", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1 chk("rst_async_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_rel_ready", 64'(in_ready), 64'd1);
        chk("rst_rel_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b1;
        send(4'h6, 32'h0, 32'h0, 1'b0);         head("rst_clears_c", 32'h0, 5'b01000);

        // Fill the queue, stall, then push and pop in the same cycle.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 4'h2; op1 = 32'h0; op2 = 32'h11;
        @(posedge clk); #1; op2 = 32'h22;
        @(posedge clk); #1; op2 = 32'h33;
        chk("full_ready_low", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk("full_held", 64'(in_ready), 64'd0);
        head("full_head_a", 32'h11, 5'b00000);
        out_ready = 1'b1;
        #1 chk("full_pop_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        head("order_b", 32'h22, 5'b00000);
        @(posedge clk); #1;
        head("order_c", 32'h33, 5'b00000);
        @(posedge clk); #1;
        chk("drained", 64'(out_valid), 64'd0);

        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            opcode    = 4'($urandom_range(0, 15));
            op1       = pick();
            op2       = pick();
            carry_clr = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst = 1'b1;
                #1 chk("rand_rst_valid", 64'(out_valid), 64'd0);
                @(posedge clk); #1;
                rst = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
